// File: rtl/fetch_pc_unit_if.sv
// Bus bundle between the fetch PC unit, the instruction memory and the decode stage.
// master: the fetch unit (drives imem_addr and the decoded if_* fields).
// slave:  the surrounding pipeline/memory (drives control, redirect and imem_data).
interface fetch_pc_unit_if #(
    parameter int ADDR_W = 20
);
    logic              stall;
    logic              flush;
    logic [31:0]       redirect_pc;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_data;
    logic              if_valid;
    logic [4:0]        if_opcode;
    logic [2:0]        if_rs;
    logic [2:0]        if_rd;
    logic [4:0]        if_shmnt;
    logic              if_is_imm;
    logic [15:0]       if_imm;
    logic [31:0]       if_next_pc;

    modport master (
        input  stall, flush, redirect_pc, imem_data,
        output imem_addr, if_valid, if_opcode, if_rs, if_rd, if_shmnt,
               if_is_imm, if_imm, if_next_pc
    );

    modport slave (
        output stall, flush, redirect_pc, imem_data,
        input  imem_addr, if_valid, if_opcode, if_rs, if_rd, if_shmnt,
               if_is_imm, if_imm, if_next_pc
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction-fetch sequencer feeding the decode stage.
// Reassembles 1-word register instructions and 2-word immediate instructions
// from a 16-bit asynchronous-read instruction memory.
// Optional feature: define FETCH_BOOT_VECTOR_EN to load the starting PC from
// memory words 0 (high half) and 1 (low half) after reset instead of RESET_PC.
//
// state        | meaning
// ST_FETCH     | address pc, decode a first word
// ST_FETCH_IMM | first word held, address pc for the immediate word
// ST_BOOT_HI   | read word 0 as pc[31:16] (boot-vector build only)
// ST_BOOT_LO   | read word 1 as pc[15:0]  (boot-vector build only)
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ADDR_W    = 20,
    parameter logic [1:0]  IMM_CLASS = 2'b11
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_pc_unit_if.master bus
);
    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_FETCH_IMM = 2'd1,
        ST_BOOT_HI   = 2'd2,
        ST_BOOT_LO   = 2'd3
    } state_e;

`ifdef FETCH_BOOT_VECTOR_EN
    localparam state_e      ST_RESET = ST_BOOT_HI;
    localparam logic [31:0] PC_RESET = 32'h0000_0000;
`else
    localparam state_e      ST_RESET = ST_FETCH;
    localparam logic [31:0] PC_RESET = RESET_PC;
`endif

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [15:0] hold_q, hold_d;
    logic        valid_q, valid_d;
    logic [15:0] word_q, word_d;
    logic        is_imm_q, is_imm_d;
    logic [15:0] imm_q, imm_d;
    logic [31:0] next_pc_q, next_pc_d;

    logic [31:0] pc_inc;
    logic        imm_word;
    logic        boot_phase;

    assign pc_inc   = pc_q + 32'd1;
    assign imm_word = (bus.imem_data[15:14] == IMM_CLASS);

    // Boot states are encoded with bit 1 set; stall and flush are ignored there.
`ifdef FETCH_BOOT_VECTOR_EN
    assign boot_phase = state_q[1];
`else
    assign boot_phase = 1'b0;
`endif

    // State and datapath registers; async reset drops any partial instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RESET;
            pc_q      <= PC_RESET;
            hold_q    <= 16'h0000;
            valid_q   <= 1'b0;
            word_q    <= 16'h0000;
            is_imm_q  <= 1'b0;
            imm_q     <= 16'h0000;
            next_pc_q <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            hold_q    <= hold_d;
            valid_q   <= valid_d;
            word_q    <= word_d;
            is_imm_q  <= is_imm_d;
            imm_q     <= imm_d;
            next_pc_q <= next_pc_d;
        end
    end

    // Next-state selection: boot sequence, then flush > stall > normal fetch.
    always_comb begin
        state_d = state_q;
        if (boot_phase) begin
            state_d = (state_q == ST_BOOT_HI) ? ST_BOOT_LO : ST_FETCH;
        end else if (bus.flush) begin
            state_d = ST_FETCH;
        end else if (!bus.stall) begin
            if (state_q == ST_FETCH_IMM) begin
                state_d = ST_FETCH;
            end else if (imm_word) begin
                state_d = ST_FETCH_IMM;
            end
        end
    end

    // Datapath next values; everything holds by default so stall is a no-op.
    always_comb begin
        pc_d      = pc_q;
        hold_d    = hold_q;
        valid_d   = valid_q;
        word_d    = word_q;
        is_imm_d  = is_imm_q;
        imm_d     = imm_q;
        next_pc_d = next_pc_q;
        if (boot_phase) begin
            valid_d = 1'b0;
            if (state_q == ST_BOOT_HI) begin
                pc_d = {bus.imem_data, pc_q[15:0]};
            end else begin
                pc_d = {pc_q[31:16], bus.imem_data};
            end
        end else if (bus.flush) begin
            pc_d    = bus.redirect_pc;
            valid_d = 1'b0;
        end else if (!bus.stall) begin
            pc_d = pc_inc;
            if (state_q == ST_FETCH_IMM) begin
                word_d    = hold_q;
                imm_d     = bus.imem_data;
                is_imm_d  = 1'b1;
                next_pc_d = pc_inc;
                valid_d   = 1'b1;
            end else if (imm_word) begin
                hold_d  = bus.imem_data;
                valid_d = 1'b0;
            end else begin
                word_d    = bus.imem_data;
                imm_d     = 16'h0000;
                is_imm_d  = 1'b0;
                next_pc_d = pc_inc;
                valid_d   = 1'b1;
            end
        end
    end

    // Memory address: fixed boot-vector words during boot, otherwise the low pc bits.
    always_comb begin
        bus.imem_addr = pc_q[ADDR_W-1:0];
        if (state_q == ST_BOOT_HI) begin
            bus.imem_addr = '0;
        end else if (state_q == ST_BOOT_LO) begin
            bus.imem_addr = {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.if_valid   = valid_q;
    assign bus.if_opcode  = word_q[15:11];
    assign bus.if_rs      = word_q[10:8];
    assign bus.if_rd      = word_q[7:5];
    assign bus.if_shmnt   = word_q[4:0];
    assign bus.if_is_imm  = is_imm_q;
    assign bus.if_imm     = imm_q;
    assign bus.if_next_pc = next_pc_q;
endmodule
